// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use stalls,
// branch squash, multi-cycle EX freeze with watchdog, and stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W         = 16,
  parameter int MD_MAX_CYCLES = 64,
  parameter int WD_W          = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WD_W-1:0]  r_wd, w_wd_nxt;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_load_use, w_stall_inc, w_flush_inc;

  assign w_load_use = ex_memread && (ex_rt != 5'd0) && id_valid &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    ex_hold     = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          w_flush_inc = 1'b1;
        end else if (md_start && !md_done) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          ex_hold     = 1'b1;
          w_stall_inc = 1'b1;
          w_wd_nxt    = WD_W'(1);
          w_state_nxt = MD_WAIT;
        end else if (w_load_use) begin
          // md_start+md_done together is a 1-cycle op and still honours load-use
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_flush  = 1'b1;
          w_stall_inc = 1'b1;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          w_wd_nxt    = '0;
          w_state_nxt = RUN;
          if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          ex_hold     = 1'b1;
          w_stall_inc = 1'b1;
          // r_wd counts hold cycles already spent; this one makes r_wd+1
          if (r_wd >= WD_W'(MD_MAX_CYCLES - 1)) begin
            w_state_nxt = TIMEOUT;
          end else begin
            w_wd_nxt = r_wd + WD_W'(1);
          end
        end
      end
      TIMEOUT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        ex_hold = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wd_nxt    = '0;
      end
    endcase
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      ex_hold    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_wd         <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
      if (w_state_nxt == TIMEOUT) begin
        r_md_timeout <= 1'b1;
      end
    end
  end

  // Counters are frozen (including clear) once the watchdog has tripped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != TIMEOUT) begin
      if (clr_cnt) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (w_stall_inc && (r_stall_cnt != '1)) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
        if (w_flush_inc && (r_flush_cnt != '1)) begin
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign md_timeout = r_md_timeout;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule
